// File: rtl/branch_predictor_gshare_if.sv
// Fetch/resolve bundle between the IF/ID pipeline (master) and the gshare next-PC predictor (slave).
interface branch_predictor_gshare_if #(
  parameter int WORD_SIZE = 16,
  parameter int HIST_BITS = 6
);
  logic                 stall;
  logic [WORD_SIZE-1:0] inst_addr;
  logic [WORD_SIZE-1:0] next_addr_seq;
  logic [WORD_SIZE-1:0] next_addr;
  logic                 pred_taken;
  logic [HIST_BITS-1:0] pred_ghr;
  logic                 res_valid;
  logic [WORD_SIZE-1:0] res_pc;
  logic                 res_taken;
  logic [WORD_SIZE-1:0] res_target;
  logic [WORD_SIZE-1:0] res_next_seq;
  logic [WORD_SIZE-1:0] res_pred_addr;
  logic [HIST_BITS-1:0] res_ghr;
  logic                 prediction_miss;

  modport master (
    output stall, inst_addr, next_addr_seq,
    output res_valid, res_pc, res_taken, res_target, res_next_seq, res_pred_addr, res_ghr,
    input  next_addr, pred_taken, pred_ghr, prediction_miss
  );

  modport slave (
    input  stall, inst_addr, next_addr_seq,
    input  res_valid, res_pc, res_taken, res_target, res_next_seq, res_pred_addr, res_ghr,
    output next_addr, pred_taken, pred_ghr, prediction_miss
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Tagged direct-mapped BTB plus gshare PHT; predicts the next fetch PC, speculates the GHR,
// and trains/repairs from branch outcomes resolved in ID.
module branch_predictor_gshare #(
  parameter int WORD_SIZE    = 16,
  parameter int BTB_IDX_BITS = 8,
  parameter int PHT_IDX_BITS = 8,
  parameter int HIST_BITS    = 6,
  parameter int CTR_BITS     = 2,
  parameter int MODE         = 0
) (
  input logic                      clk,
  input logic                      reset_n,
  branch_predictor_gshare_if.slave bp
);
  localparam int BTB_N    = 1 << BTB_IDX_BITS;
  localparam int PHT_N    = 1 << PHT_IDX_BITS;
  localparam int TAG_BITS = WORD_SIZE - BTB_IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));

  logic                 r_btb_valid  [BTB_N];
  logic [TAG_BITS-1:0]  r_btb_tag    [BTB_N];
  logic [WORD_SIZE-1:0] r_btb_target [BTB_N];
  logic [CTR_BITS-1:0]  r_pht        [PHT_N];
  logic [HIST_BITS-1:0] r_ghr;

  logic [BTB_IDX_BITS-1:0] w_fetch_bi;
  logic [TAG_BITS-1:0]     w_fetch_tag;
  logic [PHT_IDX_BITS-1:0] w_fetch_pi;
  logic                    w_hit;
  logic                    w_pred_taken;
  logic [WORD_SIZE-1:0]    w_correct_addr;
  logic                    w_miss;
  logic [BTB_IDX_BITS-1:0] w_res_bi;
  logic [TAG_BITS-1:0]     w_res_tag;
  logic [PHT_IDX_BITS-1:0] w_res_pi;
  logic [CTR_BITS-1:0]     w_res_ctr;
  logic [CTR_BITS-1:0]     w_ctr_next;

  assign w_fetch_bi  = bp.inst_addr[BTB_IDX_BITS-1:0];
  assign w_fetch_tag = bp.inst_addr[WORD_SIZE-1:BTB_IDX_BITS];
  assign w_fetch_pi  = bp.inst_addr[PHT_IDX_BITS-1:0] ^ PHT_IDX_BITS'(r_ghr);
  assign w_hit       = r_btb_valid[w_fetch_bi] && (r_btb_tag[w_fetch_bi] == w_fetch_tag);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_pred_taken = 1'b0;
    case (MODE)
      0, 1:    w_pred_taken = w_hit && r_pht[w_fetch_pi][CTR_BITS-1];
      2:       w_pred_taken = w_hit;
      default: w_pred_taken = 1'b0;
    endcase
  end

  assign w_correct_addr     = bp.res_taken ? bp.res_target : bp.res_next_seq;
  assign w_miss             = bp.res_valid && (w_correct_addr != bp.res_pred_addr);
  assign bp.prediction_miss = w_miss;
  assign bp.pred_taken      = w_pred_taken;
  assign bp.pred_ghr        = r_ghr;
  // A mispredict redirects fetch immediately, overriding whatever this fetch predicted.
  assign bp.next_addr       = w_miss       ? w_correct_addr :
                              w_pred_taken ? r_btb_target[w_fetch_bi] : bp.next_addr_seq;

  assign w_res_bi  = bp.res_pc[BTB_IDX_BITS-1:0];
  assign w_res_tag = bp.res_pc[WORD_SIZE-1:BTB_IDX_BITS];
  assign w_res_pi  = bp.res_pc[PHT_IDX_BITS-1:0] ^ PHT_IDX_BITS'(bp.res_ghr);
  assign w_res_ctr = r_pht[w_res_pi];

  // Hysteresis mode leaps over the weak states so one outcome flips a weak counter to strong.
  always_comb begin
    w_ctr_next = w_res_ctr;
    if (MODE == 1 && bp.res_taken && w_res_ctr == CTR_WNT) begin
      w_ctr_next = CTR_MAX;
    end else if (MODE == 1 && !bp.res_taken && w_res_ctr == CTR_WT) begin
      w_ctr_next = '0;
    end else if (bp.res_taken) begin
      if (w_res_ctr != CTR_MAX) w_ctr_next = w_res_ctr + 1'b1;
    end else begin
      if (w_res_ctr != '0) w_ctr_next = w_res_ctr - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all updates land together at the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ghr <= '0;
      // NOTE: the tables are reset entry by entry because cold-start predictions must be deterministic.
      for (int i = 0; i < BTB_N; i++) begin
        r_btb_valid[i]  <= 1'b0;
        r_btb_tag[i]    <= '0;
        r_btb_target[i] <= '0;
      end
      for (int i = 0; i < PHT_N; i++) begin
        r_pht[i] <= CTR_WNT;
      end
    end else begin
      if (w_miss) begin
        r_ghr <= HIST_BITS'({bp.res_ghr, bp.res_taken});
      end else if (!bp.stall) begin
        r_ghr <= HIST_BITS'({r_ghr, w_pred_taken});
      end
      if (bp.res_valid) begin
        if (MODE < 2) r_pht[w_res_pi] <= w_ctr_next;
        if (bp.res_taken) begin
          r_btb_valid[w_res_bi]  <= 1'b1;
          r_btb_tag[w_res_bi]    <= w_res_tag;
          r_btb_target[w_res_bi] <= bp.res_target;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: one saturating-counter and one hysteresis predictor driven by the same stimulus.
module tb_branch_predictor_gshare;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_gshare_if #(.WORD_SIZE(16), .HIST_BITS(6)) bp0 ();
  branch_predictor_gshare_if #(.WORD_SIZE(16), .HIST_BITS(6)) bp1 ();

  assign bp1.stall         = bp0.stall;
  assign bp1.inst_addr     = bp0.inst_addr;
  assign bp1.next_addr_seq = bp0.next_addr_seq;
  assign bp1.res_valid     = bp0.res_valid;
  assign bp1.res_pc        = bp0.res_pc;
  assign bp1.res_taken     = bp0.res_taken;
  assign bp1.res_target    = bp0.res_target;
  assign bp1.res_next_seq  = bp0.res_next_seq;
  assign bp1.res_pred_addr = bp0.res_pred_addr;
  assign bp1.res_ghr       = bp0.res_ghr;

  branch_predictor_gshare #(.MODE(0)) u_dut0 (.clk(clk), .reset_n(reset_n), .bp(bp0.slave));
  branch_predictor_gshare #(.MODE(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bp(bp1.slave));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_fetch(input logic [15:0] a, input logic s);
    bp0.inst_addr     = a;
    bp0.next_addr_seq = a + 16'd1;
    bp0.stall         = s;
  endtask

  task automatic drive_res(input logic v, input logic [15:0] pc, input logic t,
                           input logic [15:0] tgt, input logic [15:0] pa, input logic [5:0] g);
    bp0.res_valid     = v;
    bp0.res_pc        = pc;
    bp0.res_taken     = t;
    bp0.res_target    = tgt;
    bp0.res_next_seq  = pc + 16'd1;
    bp0.res_pred_addr = pa;
    bp0.res_ghr       = g;
  endtask

  task automatic res_clear();
    drive_res(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 6'h0);
  endtask

  task automatic idle(input int n);
    drive_fetch(16'h0010, 1'b0);
    res_clear();
    repeat (n) tick();
  endtask

  // Resolve with a correct prediction so the GHR is left to the (non-hitting) fetch stream.
  task automatic train(input string tag, input logic [15:0] pc, input logic t,
                       input logic [15:0] tgt, input logic [5:0] g);
    drive_fetch(16'h0010, 1'b0);
    drive_res(1'b1, pc, t, tgt, t ? tgt : pc + 16'd1, g);
    #1;
    check({tag, "_miss"}, 16'(bp0.prediction_miss), 16'h0);
    tick();
    res_clear();
  endtask

  // Stalled fetch: the prediction is visible but the GHR does not move.
  task automatic probe(input string tag, input logic [15:0] a,
                       input logic t0, input logic [15:0] n0, input logic t1, input logic [15:0] n1);
    drive_fetch(a, 1'b1);
    res_clear();
    #1;
    check({tag, "_taken0"}, 16'(bp0.pred_taken), 16'(t0));
    check({tag, "_next0"}, bp0.next_addr, n0);
    check({tag, "_taken1"}, 16'(bp1.pred_taken), 16'(t1));
    check({tag, "_next1"}, bp1.next_addr, n1);
    tick();
  endtask

  initial begin
    // Reset state
    drive_fetch(16'h0010, 1'b0);
    res_clear();
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
    check("rst_next0", bp0.next_addr, 16'h0011);
    check("rst_taken0", 16'(bp0.pred_taken), 16'h0);
    check("rst_ghr0", 16'(bp0.pred_ghr), 16'h0);
    check("rst_miss0", 16'(bp0.prediction_miss), 16'h0);
    check("rst_next1", bp1.next_addr, 16'h0011);
    tick();

    // Cold taken branch mispredicts; GHR repaired to 1, then shifted back to 0 by six not-taken fetches
    drive_res(1'b1, 16'h0020, 1'b1, 16'h0040, 16'h0021, 6'h00);
    #1;
    check("miss1_miss0", 16'(bp0.prediction_miss), 16'h1);
    check("miss1_next0", bp0.next_addr, 16'h0040);
    check("miss1_miss1", 16'(bp1.prediction_miss), 16'h1);
    tick();
    res_clear();
    #1;
    check("miss1_ghr", 16'(bp0.pred_ghr), 16'h0001);
    idle(6);
    check("shift_ghr", 16'(bp0.pred_ghr), 16'h0000);
    probe("refetch20", 16'h0020, 1'b1, 16'h0040, 1'b1, 16'h0040);

    // Saturation on pc 0x30 (MODE0) alongside hysteresis (MODE1)
    repeat (6) train("sat_t", 16'h0030, 1'b1, 16'h0050, 6'h00);
    probe("sat_6t", 16'h0030, 1'b1, 16'h0050, 1'b1, 16'h0050);
    train("sat_nt1", 16'h0030, 1'b0, 16'h0050, 6'h00);
    probe("sat_nt1", 16'h0030, 1'b1, 16'h0050, 1'b1, 16'h0050);
    train("sat_nt2", 16'h0030, 1'b0, 16'h0050, 6'h00);
    probe("sat_nt2", 16'h0030, 1'b0, 16'h0031, 1'b0, 16'h0031);
    train("sat_nt3", 16'h0030, 1'b0, 16'h0050, 6'h00);
    train("sat_nt4", 16'h0030, 1'b0, 16'h0050, 6'h00);
    train("sat_t1", 16'h0030, 1'b1, 16'h0050, 6'h00);
    probe("sat_t1", 16'h0030, 1'b0, 16'h0031, 1'b0, 16'h0031);
    train("sat_t2", 16'h0030, 1'b1, 16'h0050, 6'h00);
    probe("sat_t2", 16'h0030, 1'b1, 16'h0050, 1'b1, 16'h0050);

    // Hysteresis jumps on pc 0x60: MODE0 1,2,1,0,1,2,1  MODE1 1,3,2,0,1,3,2
    train("hy_a", 16'h0060, 1'b1, 16'h0070, 6'h00);
    probe("hy_a", 16'h0060, 1'b1, 16'h0070, 1'b1, 16'h0070);
    train("hy_b", 16'h0060, 1'b0, 16'h0070, 6'h00);
    probe("hy_b", 16'h0060, 1'b0, 16'h0061, 1'b1, 16'h0070);
    train("hy_c", 16'h0060, 1'b0, 16'h0070, 6'h00);
    probe("hy_c", 16'h0060, 1'b0, 16'h0061, 1'b0, 16'h0061);
    train("hy_d", 16'h0060, 1'b1, 16'h0070, 6'h00);
    probe("hy_d", 16'h0060, 1'b0, 16'h0061, 1'b0, 16'h0061);
    train("hy_e", 16'h0060, 1'b1, 16'h0070, 6'h00);
    probe("hy_e", 16'h0060, 1'b1, 16'h0070, 1'b1, 16'h0070);
    train("hy_f", 16'h0060, 1'b0, 16'h0070, 6'h00);
    probe("hy_f", 16'h0060, 1'b0, 16'h0061, 1'b1, 16'h0070);

    // Stall holds the GHR across a predicted-taken hit; an unstalled hit shifts in a 1
    drive_fetch(16'h0020, 1'b1);
    res_clear();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ghr", 16'(bp0.pred_ghr), 16'h0000);
      check("stall_taken", 16'(bp0.pred_taken), 16'h1);
      tick();
    end
    drive_fetch(16'h0020, 1'b0);
    tick();
    drive_fetch(16'h0010, 1'b0);
    #1;
    check("spec_ghr", 16'(bp0.pred_ghr), 16'h0001);

    // Miss repair under stall
    drive_fetch(16'h0020, 1'b1);
    drive_res(1'b1, 16'h0080, 1'b1, 16'h0090, 16'h0081, 6'h2A);
    #1;
    check("rep_t_miss", 16'(bp0.prediction_miss), 16'h1);
    check("rep_t_next", bp0.next_addr, 16'h0090);
    tick();
    res_clear();
    #1;
    check("rep_t_ghr", 16'(bp0.pred_ghr), 16'h0015);
    drive_res(1'b1, 16'h0080, 1'b0, 16'h0090, 16'h0090, 6'h3F);
    #1;
    check("rep_nt_miss", 16'(bp0.prediction_miss), 16'h1);
    check("rep_nt_next", bp0.next_addr, 16'h0081);
    tick();
    res_clear();
    #1;
    check("rep_nt_ghr", 16'(bp0.pred_ghr), 16'h003E);
    check("rep_nt_ghr1", 16'(bp1.pred_ghr), 16'h003E);

    // Tag alias: 0x0120 replaces entry 0x20; 0x0220 and 0x0020 share the index but miss on tag
    idle(6);
    check("alias_ghr", 16'(bp0.pred_ghr), 16'h0000);
    train("alias_tr", 16'h0120, 1'b1, 16'h0150, 6'h00);
    probe("alias220", 16'h0220, 1'b0, 16'h0221, 1'b0, 16'h0221);
    probe("alias120", 16'h0120, 1'b1, 16'h0150, 1'b1, 16'h0150);
    probe("alias020", 16'h0020, 1'b0, 16'h0021, 1'b0, 16'h0021);
    drive_fetch(16'h0120, 1'b0);
    tick();
    drive_fetch(16'h0010, 1'b0);
    #1;
    check("pre_rst_ghr", 16'(bp0.pred_ghr), 16'h0001);

    // Reset mid-run with a concurrent taken resolve: reset wins
    reset_n = 1'b0;
    drive_fetch(16'h0120, 1'b0);
    drive_res(1'b1, 16'h0120, 1'b1, 16'h0150, 16'h0150, 6'h00);
    tick();
    reset_n = 1'b1;
    res_clear();
    drive_fetch(16'h0120, 1'b1);
    #1;
    check("rst2_ghr", 16'(bp0.pred_ghr), 16'h0000);
    probe("rst2_btb", 16'h0120, 1'b0, 16'h0121, 1'b0, 16'h0121);
    train("rst2_t", 16'h0120, 1'b1, 16'h0150, 6'h00);
    train("rst2_nt", 16'h0120, 1'b0, 16'h0150, 6'h00);
    probe("rst2_ctr", 16'h0120, 1'b0, 16'h0121, 1'b1, 16'h0150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
